// File: rtl/mem_wb_stage.sv
// Memory-access and writeback stage: performs doubleword loads/stores on a multi-cycle
// data-memory port and drives the register-file write port.
module mem_wb_stage #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      ctrl_wb,
   input  logic [1:0]      ctrl_m,
   input  logic [XLEN-1:0] alu_result,
   input  logic [XLEN-1:0] store_data,
   input  logic [4:0]      rd,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_ack,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            op_write,
   output logic [4:0]      write_addr,
   output logic [XLEN-1:0] write_data,
   output logic            err
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
   logic [1:0]      wb_q, wb_nxt;
   logic [4:0]      rd_q, rd_nxt;
   logic            req_nxt, we_nxt, opw_nxt, err_nxt;
   logic [XLEN-1:0] addr_nxt, mwdata_nxt, wdata_nxt;
   logic [4:0]      waddr_nxt;
   logic            accept;

   assign in_ready = (state == IDLE) && !reset;
   assign accept   = in_valid && in_ready;

   // State, captured bundle and all registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         wb_q       <= '0;
         rd_q       <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         op_write   <= 1'b0;
         write_addr <= '0;
         write_data <= '0;
         err        <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         wb_q       <= wb_nxt;
         rd_q       <= rd_nxt;
         dmem_req   <= req_nxt;
         dmem_we    <= we_nxt;
         dmem_addr  <= addr_nxt;
         dmem_wdata <= mwdata_nxt;
         op_write   <= opw_nxt;
         write_addr <= waddr_nxt;
         write_data <= wdata_nxt;
         err        <= err_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      cnt_inc    = cnt + CW'(1);
      wb_nxt     = wb_q;
      rd_nxt     = rd_q;
      req_nxt    = dmem_req;
      we_nxt     = dmem_we;
      addr_nxt   = dmem_addr;
      mwdata_nxt = dmem_wdata;
      opw_nxt    = 1'b0;
      waddr_nxt  = write_addr;
      wdata_nxt  = write_data;
      err_nxt    = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               case (ctrl_m)
                  2'b00: begin
                     // MemtoReg without MemRead still selects the ALU result
                     if (ctrl_wb[0] && (rd != 5'd0)) begin
                        opw_nxt   = 1'b1;
                        waddr_nxt = rd;
                        wdata_nxt = alu_result;
                     end
                  end
                  2'b11: err_nxt = 1'b1;
                  default: begin
                     if (alu_result[2:0] != 3'd0) begin
                        err_nxt = 1'b1;
                     end else begin
                        state_nxt  = ACCESS;
                        cnt_nxt    = '0;
                        wb_nxt     = ctrl_wb;
                        rd_nxt     = rd;
                        req_nxt    = 1'b1;
                        we_nxt     = ctrl_m[0];
                        addr_nxt   = alu_result;
                        mwdata_nxt = store_data;
                     end
                  end
               endcase
            end
         end
         ACCESS: begin
            // An ack in the cycle the counter reaches TIMEOUT still completes normally
            if (dmem_ack) begin
               state_nxt = IDLE;
               req_nxt   = 1'b0;
               cnt_nxt   = '0;
               if (!dmem_we && (wb_q == 2'b11) && (rd_q != 5'd0)) begin
                  opw_nxt   = 1'b1;
                  waddr_nxt = rd_q;
                  wdata_nxt = dmem_rdata;
               end
            end else if (cnt_inc == CW'(TIMEOUT)) begin
               state_nxt = IDLE;
               req_nxt   = 1'b0;
               cnt_nxt   = '0;
               err_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: register writes are checked against a queue of
// expected (addr, data) pairs; memory handshake, errors and reset are checked per scenario.
module tb_mem_wb_stage;

   localparam int unsigned XLEN    = 64;
   localparam int unsigned TIMEOUT = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [1:0]      ctrl_wb = '0;
   logic [1:0]      ctrl_m = '0;
   logic [XLEN-1:0] alu_result = '0;
   logic [XLEN-1:0] store_data = '0;
   logic [4:0]      rd = '0;
   logic            dmem_req, dmem_we;
   logic [XLEN-1:0] dmem_addr, dmem_wdata;
   logic            dmem_ack = 1'b0;
   logic [XLEN-1:0] dmem_rdata = '0;
   logic            op_write;
   logic [4:0]      write_addr;
   logic [XLEN-1:0] write_data;
   logic            err;

   typedef struct packed {
      logic [4:0]      addr;
      logic [XLEN-1:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  pass_cnt = 0, total_cnt = 0;
   int  wr_cnt = 0, err_cnt = 0, req_cnt = 0;

   mem_wb_stage #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .ctrl_wb(ctrl_wb), .ctrl_m(ctrl_m), .alu_result(alu_result), .store_data(store_data),
      .rd(rd), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .op_write(op_write), .write_addr(write_addr), .write_data(write_data), .err(err)
   );

   always #5 clk = ~clk;

   // Scoreboard: every register write must match the oldest expected entry
   always @(negedge clk) begin
      if (dmem_req) req_cnt++;
      if (err) err_cnt++;
      if (op_write) begin
         wr_cnt++;
         total_cnt++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", write_addr, write_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (write_addr !== mon_e.addr || write_data !== mon_e.data)
               $display("FAIL write_sb: got addr=%0d data=%h, required addr=%0d data=%h",
                        write_addr, write_data, mon_e.addr, mon_e.data);
            else pass_cnt++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] wb, input logic [1:0] m,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] sd, input logic [4:0] r);
      in_valid = v; ctrl_wb = wb; ctrl_m = m; alu_result = a; store_data = sd; rd = r;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(); step();
      @(negedge clk);
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b required 0", in_ready); else pass_cnt++;
      total_cnt++; if ({dmem_req, dmem_we, op_write, err} !== 4'b0)
         $display("FAIL rst_strobes: got %b required 0000", {dmem_req, dmem_we, op_write, err}); else pass_cnt++;
      total_cnt++; if (dmem_addr !== '0 || dmem_wdata !== '0)
         $display("FAIL rst_dmem: got addr=%h wdata=%h required 0", dmem_addr, dmem_wdata); else pass_cnt++;
      total_cnt++; if (write_addr !== 5'd0 || write_data !== '0)
         $display("FAIL rst_wport: got addr=%0d data=%h required 0", write_addr, write_data); else pass_cnt++;
      step();
      reset = 1'b0;
      @(negedge clk);
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b required 1", in_ready); else pass_cnt++;
   endtask

   task automatic test_alu();
      int w0;
      logic [XLEN-1:0] v;
      logic [4:0] r, last_a;
      logic [1:0] wb;
      logic exp_ow;
      logic [XLEN-1:0] last_d;
      step();
      w0 = wr_cnt;
      drive(1'b1, 2'b01, 2'b00, 64'h1234, '0, 5'd5);
      exp_q.push_back(wr_t'{5'd5, 64'h1234});
      step();
      @(negedge clk);
      total_cnt++; if (op_write !== 1'b1 || write_addr !== 5'd5 || write_data !== 64'h1234)
         $display("FAIL add_write: got ow=%b addr=%0d data=%h required 1/5/1234", op_write, write_addr, write_data);
      else pass_cnt++;
      last_a = 5'd5; last_d = 64'h1234;
      // Back-to-back bundles, including rd=0, RegWrite=0 and MemtoReg-without-MemRead
      for (int i = 0; i < 6; i++) begin
         v  = {$urandom, $urandom};
         r  = (i == 3) ? 5'd0 : 5'(i * 3 + 2);
         wb = (i == 4) ? 2'b10 : ((i == 5) ? 2'b11 : 2'b01);
         exp_ow = wb[0] && (r != 5'd0);
         drive(1'b1, wb, 2'b00, v, '0, r);
         if (exp_ow) begin
            exp_q.push_back(wr_t'{r, v});
            last_a = r; last_d = v;
         end
         step();
         @(negedge clk);
         total_cnt++; if (op_write !== exp_ow || in_ready !== 1'b1)
            $display("FAIL b2b_%0d: got ow=%b ready=%b required ow=%b ready=1", i, op_write, in_ready, exp_ow);
         else pass_cnt++;
      end
      drive(1'b0, 2'b00, 2'b00, '0, '0, 5'd0);
      step(); step();
      total_cnt++; if (wr_cnt - w0 !== 5) $display("FAIL alu_write_count: got %0d required 5", wr_cnt - w0); else pass_cnt++;
      total_cnt++; if (exp_q.size() !== 0) $display("FAIL alu_queue: got %0d pending required 0", exp_q.size()); else pass_cnt++;
      total_cnt++; if (write_addr !== last_a || write_data !== last_d)
         $display("FAIL write_hold: got addr=%0d data=%h required addr=%0d data=%h", write_addr, write_data, last_a, last_d);
      else pass_cnt++;
   endtask

   task automatic test_load();
      int r0, w0;
      r0 = req_cnt; w0 = wr_cnt;
      drive(1'b1, 2'b11, 2'b10, 64'h40, '0, 5'd7);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin
            dmem_ack = 1'b1; dmem_rdata = 64'hDEADBEEF;
            exp_q.push_back(wr_t'{5'd7, 64'hDEADBEEF});
         end
         @(negedge clk);
         total_cnt++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 64'h40 || in_ready !== 1'b0)
            $display("FAIL load_req_%0d: got req=%b we=%b addr=%h ready=%b required 1/0/40/0", i, dmem_req, dmem_we, dmem_addr, in_ready);
         else pass_cnt++;
         step();
      end
      dmem_ack = 1'b0; dmem_rdata = '0;
      @(negedge clk);
      total_cnt++; if (dmem_req !== 1'b0 || op_write !== 1'b1 || in_ready !== 1'b1)
         $display("FAIL load_done: got req=%b ow=%b ready=%b required 0/1/1", dmem_req, op_write, in_ready);
      else pass_cnt++;
      step();
      total_cnt++; if (req_cnt - r0 !== 3 || wr_cnt - w0 !== 1 || exp_q.size() !== 0)
         $display("FAIL load_counts: got req=%0d wr=%0d pending=%0d required 3/1/0", req_cnt - r0, wr_cnt - w0, exp_q.size());
      else pass_cnt++;
   endtask

   task automatic test_store();
      int r0, w0;
      r0 = req_cnt; w0 = wr_cnt;
      drive(1'b1, 2'b01, 2'b01, 64'h88, 64'hCAFE, 5'd9);
      step();
      in_valid = 1'b0; store_data = '0;
      for (int i = 0; i < 2; i++) begin
         if (i == 1) dmem_ack = 1'b1;
         @(negedge clk);
         total_cnt++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 64'h88 || dmem_wdata !== 64'hCAFE)
            $display("FAIL store_req_%0d: got req=%b we=%b addr=%h wdata=%h required 1/1/88/cafe", i, dmem_req, dmem_we, dmem_addr, dmem_wdata);
         else pass_cnt++;
         step();
      end
      dmem_ack = 1'b0;
      step();
      total_cnt++; if (req_cnt - r0 !== 2 || wr_cnt - w0 !== 0 || in_ready !== 1'b1)
         $display("FAIL store_counts: got req=%0d wr=%0d ready=%b required 2/0/1", req_cnt - r0, wr_cnt - w0, in_ready);
      else pass_cnt++;
   endtask

   task automatic test_errors();
      int r0, w0, e0;
      logic [1:0] wb_t[3] = '{2'b11, 2'b11, 2'b00};
      logic [1:0] m_t[3]  = '{2'b10, 2'b11, 2'b01};
      logic [XLEN-1:0] a_t[3] = '{64'h42, 64'h40, 64'h44};
      for (int i = 0; i < 3; i++) begin
         r0 = req_cnt; w0 = wr_cnt; e0 = err_cnt;
         drive(1'b1, wb_t[i], m_t[i], a_t[i], 64'h55, 5'd3);
         step();
         in_valid = 1'b0;
         @(negedge clk);
         total_cnt++; if (err !== 1'b1 || dmem_req !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL err_pulse_%0d: got err=%b req=%b ready=%b required 1/0/1", i, err, dmem_req, in_ready);
         else pass_cnt++;
         step();
         @(negedge clk);
         total_cnt++; if (err !== 1'b0) $display("FAIL err_width_%0d: got %b required 0", i, err); else pass_cnt++;
         step();
         total_cnt++; if (err_cnt - e0 !== 1 || req_cnt - r0 !== 0 || wr_cnt - w0 !== 0)
            $display("FAIL err_counts_%0d: got err=%0d req=%0d wr=%0d required 1/0/0", i, err_cnt - e0, req_cnt - r0, wr_cnt - w0);
         else pass_cnt++;
      end
   endtask

   task automatic test_timeout(input logic ack_last);
      int r0, w0, e0, seen;
      logic rdy_at_err;
      r0 = req_cnt; w0 = wr_cnt; e0 = err_cnt; seen = -1; rdy_at_err = 1'b0;
      drive(1'b1, 2'b11, 2'b10, ack_last ? 64'h108 : 64'h100, '0, 5'd6);
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (ack_last && i == 3) begin
            dmem_ack = 1'b1; dmem_rdata = 64'h0123_4567_89AB_CDEF;
            exp_q.push_back(wr_t'{5'd6, 64'h0123_4567_89AB_CDEF});
         end
         @(negedge clk);
         if (err === 1'b1 && seen < 0) begin seen = i; rdy_at_err = in_ready; end
         step();
         dmem_ack = 1'b0;
      end
      total_cnt++; if (req_cnt - r0 !== 4)
         $display("FAIL to_req_cycles_%0d: got %0d required 4", ack_last, req_cnt - r0); else pass_cnt++;
      if (ack_last) begin
         total_cnt++; if (err_cnt - e0 !== 0 || wr_cnt - w0 !== 1)
            $display("FAIL ack_at_timeout: got err=%0d wr=%0d required 0/1", err_cnt - e0, wr_cnt - w0);
         else pass_cnt++;
      end else begin
         total_cnt++; if (seen !== 4 || rdy_at_err !== 1'b1 || err_cnt - e0 !== 1 || wr_cnt - w0 !== 0)
            $display("FAIL timeout: got err_at=%0d ready=%b errs=%0d wr=%0d required 4/1/1/0", seen, rdy_at_err, err_cnt - e0, wr_cnt - w0);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid();
      int r0, w0, e0;
      logic [4:0] a0;
      logic [XLEN-1:0] d0;
      r0 = req_cnt; w0 = wr_cnt; e0 = err_cnt; a0 = write_addr; d0 = write_data;
      drive(1'b1, 2'b11, 2'b10, 64'h200, '0, 5'd8);
      step();
      in_valid = 1'b0;
      step();
      reset = 1'b1;
      @(negedge clk);
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL mid_rst_ready: got %b required 0", in_ready); else pass_cnt++;
      step();
      reset = 1'b0;
      @(negedge clk);
      total_cnt++; if (dmem_req !== 1'b0) $display("FAIL mid_rst_req: got %b required 0", dmem_req); else pass_cnt++;
      step();
      dmem_ack = 1'b1; dmem_rdata = 64'hBAD;
      step();
      dmem_ack = 1'b0;
      step(); step();
      total_cnt++; if (req_cnt - r0 !== 2 || wr_cnt - w0 !== 0 || err_cnt - e0 !== 0)
         $display("FAIL mid_rst_counts: got req=%0d wr=%0d err=%0d required 2/0/0", req_cnt - r0, wr_cnt - w0, err_cnt - e0);
      else pass_cnt++;
      total_cnt++; if (write_data !== '0 || write_addr !== 5'd0)
         $display("FAIL mid_rst_wport: got addr=%0d data=%h required 0 (was %0d/%h)", write_addr, write_data, a0, d0);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int r0, w0;
      r0 = req_cnt; w0 = wr_cnt;
      // Load to rd=0 then minimum-latency load to rd=3, both acked in their first req cycle
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 2'b11, 2'b10, 64'h300 + 64'(i * 8), '0, (i == 0) ? 5'd0 : 5'd3);
         step();
         in_valid = 1'b0;
         dmem_ack = 1'b1; dmem_rdata = 64'hF00D_0000 + 64'(i);
         if (i == 1) exp_q.push_back(wr_t'{5'd3, 64'hF00D_0001});
         step();
         dmem_ack = 1'b0;
         @(negedge clk);
         total_cnt++; if (dmem_req !== 1'b0 || op_write !== 1'(i) || in_ready !== 1'b1)
            $display("FAIL min_lat_%0d: got req=%b ow=%b ready=%b required 0/%0d/1", i, dmem_req, op_write, in_ready, i);
         else pass_cnt++;
         step();
      end
      // Ack while idle does nothing
      dmem_ack = 1'b1;
      step(); step();
      dmem_ack = 1'b0;
      step();
      total_cnt++; if (req_cnt - r0 !== 2 || wr_cnt - w0 !== 1 || exp_q.size() !== 0)
         $display("FAIL idle_ack_counts: got req=%0d wr=%0d pending=%0d required 2/1/0", req_cnt - r0, wr_cnt - w0, exp_q.size());
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_errors();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d passed", pass_cnt, total_cnt);
      $fatal(1);
   end

endmodule
